// File: rtl/axi_slave_mem.sv
// AXI4 burst slave memory: independent write/read FSMs over a DEPTH x DATA_WIDTH byte-lane RAM.
// Define AXI_SLV_BACKPRESSURE_EN for LFSR-driven WREADY / R-launch stalls; default build never stalls.
module axi_slave_mem #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic                    S_AXI_RLAST,
  output logic [1:0]              S_AXI_RRESP
);
  localparam int ADDRLSB = $clog2(DATA_WIDTH) - 3;
  localparam int WAW     = ADDR_WIDTH - ADDRLSB;
  localparam int DEPTH   = 1 << WAW;
  localparam int NSTRB   = DATA_WIDTH / 8;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sizes and sub-word address bits carry no meaning: every beat is full width.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWADDR, S_AXI_ARADDR};

  logic stall;
`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [7:0] lfsr;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t        w_state;
  logic [WAW-1:0]  w_addr;
  logic [7:0]      w_len;
  logic [7:0]      w_cnt;
  logic            w_ok;
  logic            w_en;
  logic            w_hs;
  logic            w_last_beat;

  assign S_AXI_WREADY = w_en && !stall;
  assign w_hs         = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last_beat  = (w_cnt == w_len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_BID     <= '0;
      w_en          <= 1'b0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_ok          <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (S_AXI_AWVALID) begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_BID     <= S_AXI_AWID;
          w_addr        <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDRLSB];
          w_len         <= S_AXI_AWLEN;
          w_cnt         <= '0;
          w_ok          <= (S_AXI_AWBURST == BURST_INCR);
          w_en          <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_addr <= w_addr + 1'b1;
          w_cnt  <= w_cnt + 1'b1;
          // Burst closes on WLAST or on the AWLEN+1th beat; any disagreement is a slave error.
          if (S_AXI_WLAST || w_last_beat) begin
            w_en         <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= (!w_ok || (S_AXI_WLAST != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID  <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && w_ok) begin
      for (int i = 0; i < NSTRB; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_addr][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t        r_state;
  logic [WAW-1:0]  r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic            r_ok;
  logic [WAW-1:0]  f_addr;
  logic [7:0]      f_idx;
  logic [7:0]      f_len;
  logic            f_ok;
  logic            r_done;
  logic            r_launch;

  // The first beat is fetched straight from the AR channel so it appears the cycle after AR.
  always_comb begin
    f_addr = r_addr;
    f_idx  = r_cnt;
    f_len  = r_len;
    f_ok   = r_ok;
    if (r_state == R_IDLE) begin
      f_addr = S_AXI_ARADDR[ADDR_WIDTH-1:ADDRLSB];
      f_idx  = '0;
      f_len  = S_AXI_ARLEN;
      f_ok   = (S_AXI_ARBURST == BURST_INCR);
    end
  end

  assign r_done   = S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST;
  assign r_launch = !stall &&
                    ((r_state == R_IDLE && S_AXI_ARVALID) ||
                     (r_state == R_DATA && !r_done && (!S_AXI_RVALID || S_AXI_RREADY)));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_ok          <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI_ARVALID) begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RID     <= S_AXI_ARID;
          r_len         <= S_AXI_ARLEN;
          r_ok          <= f_ok;
          r_addr        <= f_addr;
          r_cnt         <= '0;
          r_state       <= R_DATA;
        end
        R_DATA: begin
          if (r_done) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
      // Memory read here sees the pre-write word when a W beat hits the same address this cycle.
      if (r_launch) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= f_ok ? mem[f_addr] : '0;
        S_AXI_RRESP  <= f_ok ? RESP_OKAY : RESP_SLVERR;
        S_AXI_RLAST  <= (f_idx == f_len);
        r_addr       <= f_addr + 1'b1;
        r_cnt        <= f_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: scoreboard of expected B/R responses from a word-array memory model.
module tb_axi_slave_mem;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        S_AXI_AWVALID = 0, S_AXI_AWREADY;
  logic [0:0]  S_AXI_AWID = 0;
  logic [9:0]  S_AXI_AWADDR = 0;
  logic [7:0]  S_AXI_AWLEN = 0;
  logic [2:0]  S_AXI_AWSIZE = 3'd2;
  logic [1:0]  S_AXI_AWBURST = 0;
  logic        S_AXI_WVALID = 0, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA = 0;
  logic [3:0]  S_AXI_WSTRB = 0;
  logic        S_AXI_WLAST = 0;
  logic        S_AXI_BVALID, S_AXI_BREADY = 1;
  logic [0:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID = 0, S_AXI_ARREADY;
  logic [0:0]  S_AXI_ARID = 0;
  logic [9:0]  S_AXI_ARADDR = 0;
  logic [7:0]  S_AXI_ARLEN = 0;
  logic [2:0]  S_AXI_ARSIZE = 3'd2;
  logic [1:0]  S_AXI_ARBURST = 0;
  logic        S_AXI_RVALID, S_AXI_RREADY = 1;
  logic [0:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic        S_AXI_RLAST;
  logic [1:0]  S_AXI_RRESP;

  always #5 ACLK = ~ACLK;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWID(S_AXI_AWID),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BID(S_AXI_BID),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARID(S_AXI_ARID),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RID(S_AXI_RID),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RRESP(S_AXI_RRESP)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model [256];

  typedef struct { logic [31:0] data; logic last; logic [1:0] resp; logic id; } rexp_t;
  typedef struct { logic [1:0] resp; logic id; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: every R/B handshake against the scoreboard, plus hold stability.
  logic        pr_hold = 0, pb_hold = 0;
  logic [31:0] pr_data;
  logic        pr_last, pr_id, pb_id;
  logic [1:0]  pr_resp, pb_resp;
  rexp_t       re;
  bexp_t       be;
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (pr_hold) begin
        chk("r_hold_valid", S_AXI_RVALID, 1);
        chk("r_hold_data", S_AXI_RDATA, pr_data);
        chk("r_hold_last", S_AXI_RLAST, pr_last);
        chk("r_hold_id", S_AXI_RID, pr_id);
      end
      if (pb_hold) begin
        chk("b_hold_valid", S_AXI_BVALID, 1);
        chk("b_hold_id", S_AXI_BID, pb_id);
        chk("b_hold_resp", S_AXI_BRESP, pb_resp);
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected_beat", S_AXI_RVALID, 0);
        else begin
          re = rq.pop_front();
          chk("rdata", S_AXI_RDATA, re.data);
          chk("rlast", S_AXI_RLAST, re.last);
          chk("rresp", S_AXI_RRESP, re.resp);
          chk("rid", S_AXI_RID, re.id);
          got.push_back(S_AXI_RDATA);
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", S_AXI_BVALID, 0);
        else begin
          be = bq.pop_front();
          chk("bresp", S_AXI_BRESP, be.resp);
          chk("bid", S_AXI_BID, be.id);
        end
      end
      pr_hold = S_AXI_RVALID && !S_AXI_RREADY;
      pr_data = S_AXI_RDATA; pr_last = S_AXI_RLAST; pr_id = S_AXI_RID; pr_resp = S_AXI_RRESP;
      pb_hold = S_AXI_BVALID && !S_AXI_BREADY;
      pb_id = S_AXI_BID; pb_resp = S_AXI_BRESP;
    end else begin
      pr_hold = 0;
      pb_hold = 0;
    end
  end

  task automatic send_aw(input logic [9:0] a, input logic [7:0] len, input logic [1:0] b, input logic id);
    int n = 0;
    S_AXI_AWVALID = 1; S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWBURST = b; S_AXI_AWID = id;
    @(negedge ACLK);
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("aw_ready", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n = 0;
    S_AXI_WVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = strb; S_AXI_WLAST = last;
    @(negedge ACLK);
    while (!S_AXI_WREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("w_ready", S_AXI_WREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
  endtask

  // last_at: beat index carrying WLAST (beyond len means WLAST never asserted).
  task automatic write_burst(input logic [9:0] a, input logic [7:0] len, input logic [1:0] b,
                             input logic id, input int last_at, input logic [3:0] strb,
                             input logic [31:0] base, input logic [31:0] step, input int bstall);
    int nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    logic [7:0] w = a[9:2];
    logic [31:0] d;
    bexp_t e;
    int n = 0;
    e.resp = (b == 2'b01 && last_at == int'(len)) ? 2'b00 : 2'b10;
    e.id = id;
    bq.push_back(e);
    S_AXI_BREADY = (bstall == 0);
    send_aw(a, len, b, id);
    for (int i = 0; i < nb; i++) begin
      d = base + step * i;
      if (b == 2'b01)
        for (int k = 0; k < 4; k++) if (strb[k]) model[w][8*k +: 8] = d[8*k +: 8];
      w++;
      send_w(d, strb, i == last_at);
    end
    @(negedge ACLK);
    chk("bvalid_latency", S_AXI_BVALID, 1);
    if (bstall > 0) begin
      repeat (bstall) @(posedge ACLK);
      #1 S_AXI_BREADY = 1;
    end
    while (bq.size() > 0 && n < 100) begin @(posedge ACLK); #1; n++; end
    chk("b_pending", bq.size(), 0);
    bq.delete();
    chk("awready_back", S_AXI_AWREADY, 1);
  endtask

  task automatic read_burst(input logic [9:0] a, input logic [7:0] len, input logic [1:0] b,
                            input logic id, input int gap_at, input int gap_len);
    logic [7:0] w = a[9:2];
    rexp_t e;
    int n = 0;
    int gl = gap_len;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = (b == 2'b01) ? model[w] : 32'h0;
      e.last = (i == int'(len));
      e.resp = (b == 2'b01) ? 2'b00 : 2'b10;
      e.id = id;
      rq.push_back(e);
      w++;
    end
    got.delete();
    S_AXI_RREADY = 1;
    S_AXI_ARVALID = 1; S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARBURST = b; S_AXI_ARID = id;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("ar_ready", S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    @(negedge ACLK);
    chk("rvalid_latency", S_AXI_RVALID, 1);
    n = 0;
    while (rq.size() > 0 && n < 1000) begin
      @(posedge ACLK); #1; n++;
      if (gl > 0 && got.size() == gap_at) begin
        S_AXI_RREADY = 0;
        repeat (gl) begin @(posedge ACLK); #1; end
        S_AXI_RREADY = 1;
        gl = 0;
      end
    end
    chk("r_pending", rq.size(), 0);
    rq.delete();
    chk("arready_back", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AXI_AWREADY, 1);
    chk("rst_arready", S_AXI_ARREADY, 1);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rlast", S_AXI_RLAST, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_bid", S_AXI_BID, 0);
    chk("rst_rid", S_AXI_RID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    ARESETn = 1;
    @(posedge ACLK); #1;

    // 4-beat INCR write/read at address 0
    write_burst(10'h000, 8'd3, 2'b01, 1'b0, 3, 4'hF, 32'h11, 32'h11, 0);
    read_burst(10'h000, 8'd3, 2'b01, 1'b0, -1, 0);
    chk("lit_beat0", got[0], 32'h11);
    chk("lit_beat1", got[1], 32'h22);
    chk("lit_beat2", got[2], 32'h33);
    chk("lit_beat3", got[3], 32'h44);

    // Byte-strobe partial write
    write_burst(10'h014, 8'd0, 2'b01, 1'b1, 0, 4'hF, 32'hFFFFFFFF, 32'h0, 0);
    write_burst(10'h014, 8'd0, 2'b01, 1'b1, 0, 4'h3, 32'h00000000, 32'h0, 0);
    read_burst(10'h014, 8'd0, 2'b01, 1'b1, -1, 0);
    chk("lit_strb_word5", got[0], 32'hFFFF0000);

    // Address wrap 255 -> 0
    write_burst(10'h3FC, 8'd1, 2'b01, 1'b0, 1, 4'hF, 32'hAAAA0001, 32'h1, 0);
    read_burst(10'h3FC, 8'd1, 2'b01, 1'b0, -1, 0);
    chk("lit_wrap_w255", got[0], 32'hAAAA0001);
    read_burst(10'h000, 8'd0, 2'b01, 1'b0, -1, 0);
    chk("lit_wrap_w0", got[0], 32'hAAAA0002);

    // Early WLAST, missing WLAST, FIXED write and FIXED read
    write_burst(10'h040, 8'd3, 2'b01, 1'b1, 1, 4'hF, 32'h5000, 32'h1, 0);
    read_burst(10'h040, 8'd1, 2'b01, 1'b1, -1, 0);
    write_burst(10'h200, 8'd1, 2'b01, 1'b0, 5, 4'hF, 32'h9000, 32'h1, 0);
    write_burst(10'h080, 8'd1, 2'b01, 1'b0, 1, 4'hF, 32'h77770000, 32'h1, 0);
    write_burst(10'h080, 8'd1, 2'b00, 1'b0, 1, 4'hF, 32'h12345678, 32'h0, 0);
    read_burst(10'h080, 8'd1, 2'b01, 1'b0, -1, 0);
    chk("lit_fixed_nowrite", got[0], 32'h77770000);
    read_burst(10'h080, 8'd1, 2'b00, 1'b1, -1, 0);
    chk("lit_fixed_rdata", got[1], 32'h0);

    // Backpressure on R and B
    read_burst(10'h000, 8'd3, 2'b01, 1'b0, 2, 5);
    write_burst(10'h100, 8'd2, 2'b01, 1'b1, 2, 4'hF, 32'hB0, 32'h1, 3);

    // Reset in the middle of a write and a read burst
    send_aw(10'h100, 8'd3, 2'b01, 1'b1);
    model[64] = 32'hCAFE0001;
    send_w(32'hCAFE0001, 4'hF, 1'b0);
    S_AXI_RREADY = 0;
    S_AXI_ARVALID = 1; S_AXI_ARADDR = 10'h000; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'b01;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 0;
    #1;
    chk("mid_rst_rvalid", S_AXI_RVALID, 0);
    chk("mid_rst_bvalid", S_AXI_BVALID, 0);
    chk("mid_rst_wready", S_AXI_WREADY, 0);
    chk("mid_rst_awready", S_AXI_AWREADY, 1);
    chk("mid_rst_arready", S_AXI_ARREADY, 1);
    chk("mid_rst_rlast", S_AXI_RLAST, 0);
    chk("mid_rst_rdata", S_AXI_RDATA, 0);
    S_AXI_RREADY = 1;
    @(posedge ACLK); #1 ARESETn = 1;
    @(posedge ACLK); #1;
    read_burst(10'h100, 8'd0, 2'b01, 1'b1, -1, 0);
    chk("lit_mem_kept", got[0], 32'hCAFE0001);
    write_burst(10'h008, 8'd1, 2'b01, 1'b0, 1, 4'hF, 32'hD00D0000, 32'h10, 0);
    read_burst(10'h008, 8'd1, 2'b01, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; ADDRLSB = clog2(DATA_WIDTH)-3; DEPTH = 2^(ADDR_WIDTH-ADDRLSB) words.
REQ-004 SHALL have ports ACLK (in, 1, clock) and ARESETn (in, 1, reset). One clock. Reset is asynchronous and active-low.
REQ-005 SHALL have AW ports S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWID in ID_WIDTH, S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2.
REQ-006 SHALL have W ports S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_WDATA in DATA_WIDTH, S_AXI_WSTRB in DATA_WIDTH/8, S_AXI_WLAST in 1.
REQ-007 SHALL have B ports S_AXI_BVALID out 1, S_AXI_BREADY in 1, S_AXI_BID out ID_WIDTH, S_AXI_BRESP out 2.
REQ-008 SHALL have AR ports S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST (same widths/directions as AW).
REQ-009 SHALL have R ports S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RID out ID_WIDTH, S_AXI_RDATA out DATA_WIDTH, S_AXI_RLAST out 1, S_AXI_RRESP out 2.

Function
REQ-010 SHALL model a DEPTH x DATA_WIDTH memory as the downstream target of the DMA-style AXI master: write and read paths are independent and may run concurrently.
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; AW handshake latches ID, word address, AWLEN, and burst-ok flag (AWBURST==INCR), then moves to W_DATA.
REQ-012 In W_DATA, WREADY SHALL be 1 (subject to REQ-024); each W handshake writes byte lanes whose WSTRB bit is set, if burst-ok, and increments the word address by 1.
REQ-013 Word address SHALL wrap modulo DEPTH; no error on wrap.
REQ-014 Beat counter SHALL count accepted beats; burst ends on the beat with WLAST=1 or on beat AWLEN+1, whichever comes first; FSM then enters W_RESP with BVALID=1 the next cycle.
REQ-015 BRESP SHALL be 2'b00 (OKAY) unless AWBURST!=INCR or WLAST position mismatched AWLEN+1 (early WLAST, or missing on last beat), then 2'b10 (SLVERR); BID = latched AWID.
REQ-016 BVALID SHALL hold until BREADY; on handshake return to W_IDLE (AWREADY=1 next cycle).
REQ-017 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; AR handshake in cycle N SHALL give RVALID=1 with first beat registered in cycle N+1.
REQ-018 RDATA/RLAST/RID SHALL hold stable while RVALID=1 and RREADY=0; next beat presented the cycle after each R handshake; no bubbles without REQ-024 stalls.
REQ-019 RLAST SHALL be 1 exactly on beat ARLEN+1; after its handshake return to R_IDLE.
REQ-020 ARBURST!=INCR SHALL still return ARLEN+1 beats with RDATA=0 and RRESP=2'b10; otherwise RRESP=2'b00.
REQ-021 Same-cycle write and read-fetch of the same word SHALL return the old (pre-write) data.
REQ-022 AWSIZE/ARSIZE SHALL be ignored; every beat is full width.

Reset
REQ-023 On ARESETn low (any time, mid-burst included): both FSMs to idle, AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0, RRESP=0, BID=0, RID=0, RDATA=0, LFSR=8'hA5; memory contents not cleared.

Configuration
REQ-024 Macro AXI_SLV_BACKPRESSURE_EN defined: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advancing every cycle; when lfsr[1:0]==2'b00, WREADY forced 0 and no new R beat is launched (a held RVALID beat stays valid); undefined: no stalls, WREADY continuous in W_DATA.

Verification
REQ-025 Reset, AW addr 0x000 len 3 INCR, 4 beats 0x11..0x44 strb 0xF -> BVALID one cycle after 4th beat, BRESP 00; AR addr 0x000 len 3 -> RDATA 0x11,0x22,0x33,0x44, RLAST on 4th.
REQ-026 Write 0xFFFFFFFF to word 5 then 0x00000000 with WSTRB 0x3 -> read word 5 = 0xFFFF0000.
REQ-027 AW addr 0x3FC len 1 (DEPTH 256) -> beats land in word 255 then word 0; readback confirms wrap.
REQ-028 AWLEN 3 with WLAST on beat 2 -> burst ends, BRESP 2'b10; ARBURST 2'b00 len 1 -> 2 beats RDATA 0, RRESP 2'b10.
REQ-029 RREADY low 5 cycles mid-burst, BREADY low 3 cycles -> RDATA/RLAST and BVALID/BID held stable; ARESETn pulse mid-burst -> all valids 0, ready signals per REQ-023.
REQ-030 With AXI_SLV_BACKPRESSURE_EN, 256-beat write + read -> data intact, stall cycles match LFSR pattern from seed 8'hA5.
